// File: rtl/width_pack_fifo_if.sv
// Handshake and status bundle for width_pack_fifo: beat writes in, packed words out.
interface width_pack_fifo_if #(
   parameter int IN_W       = 128,
   parameter int BEATS      = 2,
   parameter int LAST_W     = 64,
   parameter int DEPTH_LOG2 = 10,
   parameter int DIV_W      = 6
);
   localparam int OUT_W = IN_W*(BEATS-1) + LAST_W;
   localparam int PH_W  = $clog2(BEATS);

   logic                  flush;
   logic                  wr;
   logic [IN_W-1:0]       data_in;
   logic                  rd;
   logic [DIV_W-1:0]      rd_div;
   logic [DEPTH_LOG2:0]   afull_th;
   logic [DEPTH_LOG2:0]   aempty_th;
   logic                  err_clr;

   logic [OUT_W-1:0]      data_out;
   logic                  rd_valid;
   logic                  rd_en_out;
   logic [DEPTH_LOG2:0]   word_count;
   logic [PH_W-1:0]       beat_phase;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  overflow;
   logic                  underflow;

   modport slave (
      input  flush, wr, data_in, rd, rd_div, afull_th, aempty_th, err_clr,
      output data_out, rd_valid, rd_en_out, word_count, beat_phase,
             full, empty, almost_full, almost_empty, overflow, underflow
   );

   modport master (
      output flush, wr, data_in, rd, rd_div, afull_th, aempty_th, err_clr,
      input  data_out, rd_valid, rd_en_out, word_count, beat_phase,
             full, empty, almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/width_pack_fifo.sv
// Packing FIFO: BEATS input beats form one word; words are read out at a paced rate.
// Storage is one synchronous-read array per lane so the final lane can be narrower.
module width_pack_fifo #(
   parameter int IN_W       = 128,
   parameter int BEATS      = 2,
   parameter int LAST_W     = 64,
   parameter int DEPTH_LOG2 = 10,
   parameter int DIV_W      = 6
) (
   input  logic                clk,
   input  logic                rstn,
   width_pack_fifo_if.slave    bus
);
   localparam int OUT_W = IN_W*(BEATS-1) + LAST_W;
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int PH_W  = $clog2(BEATS);
   localparam int CNT_W = DEPTH_LOG2 + 1;

   logic [DEPTH_LOG2-1:0] w_ptr_q, r_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [PH_W-1:0]       phase_q;
   logic [DIV_W-1:0]      tick_cnt_q;
   logic                  rd_valid_q;
   logic                  ovf_q, unf_q;

   logic tick, full, empty, wr_en, rd_en, last_beat, commit;

   assign tick      = (tick_cnt_q >= bus.rd_div);
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign wr_en     = bus.wr & ~full & ~bus.flush;
   assign rd_en     = bus.rd & tick & ~empty & ~bus.flush;
   assign last_beat = (phase_q == PH_W'(BEATS-1));
   assign commit    = wr_en & last_beat;

   // Full lanes; each keeps its own read register assembled into data_out.
   for (genvar l = 0; l < BEATS-1; l++) begin : g_lane
      logic [IN_W-1:0] mem [DEPTH];
      logic [IN_W-1:0] lane_q;

      always_ff @(posedge clk) begin
         if (wr_en && phase_q == PH_W'(l))
            mem[w_ptr_q] <= bus.data_in;
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn)
            lane_q <= '0;
         else if (rd_en)
            lane_q <= mem[r_ptr_q];
      end

      assign bus.data_out[l*IN_W +: IN_W] = lane_q;
   end

   logic [LAST_W-1:0] mem_last [DEPTH];
   logic [LAST_W-1:0] last_q;

   always_ff @(posedge clk) begin
      if (commit)
         mem_last[w_ptr_q] <= bus.data_in[LAST_W-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         last_q <= '0;
      else if (rd_en)
         last_q <= mem_last[r_ptr_q];
   end

   assign bus.data_out[OUT_W-1 -: LAST_W] = last_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_ptr_q    <= '0;
         r_ptr_q    <= '0;
         count_q    <= '0;
         phase_q    <= '0;
         tick_cnt_q <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         // Pacing free-runs through flush so the read cadence is undisturbed.
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         rd_valid_q <= rd_en;
         if (bus.flush) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            phase_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
         end else begin
            if (wr_en) begin
               phase_q <= last_beat ? '0 : phase_q + 1'b1;
               if (last_beat)
                  w_ptr_q <= w_ptr_q + 1'b1;
            end
            if (rd_en)
               r_ptr_q <= r_ptr_q + 1'b1;
            if (commit && !rd_en)
               count_q <= count_q + 1'b1;
            else if (!commit && rd_en)
               count_q <= count_q - 1'b1;
            if (bus.wr && full)
               ovf_q <= 1'b1;
            else if (bus.err_clr)
               ovf_q <= 1'b0;
            if (bus.rd && tick && empty)
               unf_q <= 1'b1;
            else if (bus.err_clr)
               unf_q <= 1'b0;
         end
      end
   end

   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_en_out    = rd_en;
   assign bus.word_count   = count_q;
   assign bus.beat_phase   = phase_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= bus.afull_th);
   assign bus.almost_empty = (count_q <= bus.aempty_th);
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: doc/width_pack_fifo.md
# width_pack_fifo

Parametrised packing FIFO for the Driver datapath. It assembles `BEATS` consecutive input beats of `IN_W` bits into one `OUT_W`-bit word and buffers up to `2**DEPTH_LOG2` words. Words are released at a runtime-programmable read rate. It adds programmable almost-full/almost-empty thresholds, an exact word count, sticky error flags with clear, and a synchronous flush.

## Interface
- `IN_W`, 128: input beat width.
- `BEATS`, 2: beats per output word, ≥2.
- `LAST_W`, 64: low bits of the final beat kept, 1..`IN_W`.
- `OUT_W`, derived localparam: `IN_W*(BEATS-1)+LAST_W` (192 at defaults).
- `DEPTH_LOG2`, 10: storage depth is `2**DEPTH_LOG2` words.
- `DIV_W`, 6: width of `rd_div`.
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `flush`, in, 1: synchronous clear of FIFO state.
- `wr`, in, 1: write request for one beat.
- `data_in`, in, `IN_W`: beat data.
- `rd`, in, 1: read request.
- `rd_div`, in, `DIV_W`: read pacing; a read opportunity occurs every `rd_div+1` cycles.
- `afull_th`, in, `DEPTH_LOG2+1`: almost-full threshold, in words.
- `aempty_th`, in, `DEPTH_LOG2+1`: almost-empty threshold, in words.
- `err_clr`, in, 1: clears the sticky error flags.
- `data_out`, out, `OUT_W`: registered read word. Beat 0 occupies the LSBs.
- `rd_valid`, out, 1: one-cycle pulse; `data_out` holds a new word.
- `rd_en_out`, out, 1: combinational accepted-read strobe.
- `word_count`, out, `DEPTH_LOG2+1`: committed words, 0..DEPTH.
- `beat_phase`, out, `$clog2(BEATS)`: index of the next beat to be written.
- `full`, `empty`, `almost_full`, `almost_empty`, out, 1: status flags.
- `overflow`, `underflow`, out, 1: sticky error flags.

## Operation
- **Write accept:** `wr_en = wr & ~full & ~flush`.
  - Each accepted beat stores into lane `beat_phase` of word slot `w_ptr`.
  - Lanes `0..BEATS-2` keep all `IN_W` bits. Lane `BEATS-1` keeps `data_in[LAST_W-1:0]`.
  - `beat_phase` advances by one and wraps to 0 after `BEATS-1`.
- **Commit:** the final beat commits the word. `w_ptr` increments at the same edge and wraps mod DEPTH.
  - Partially assembled words are invisible to the reader and are not counted.
- **Read pacing:** tick counter runs 0..`rd_div`.
  - `tick = (cnt >= rd_div)`; on tick, `cnt` returns to 0.
  - A change to `rd_div` takes effect immediately.
  - `rd_div=0` gives a tick every cycle.
- **Read accept:** `rd_en = rd & tick & ~empty & ~flush`.
  - On `rd_en`, `data_out <= mem[r_ptr]` and `r_ptr` increments, wrapping mod DEPTH.
  - `data_out` holds its value otherwise.
- **Count:** commit-only gives +1, read-only gives −1, commit and read together give no change. Never exceeds DEPTH or goes below 0.
- **Flags**, combinational from the count register:
  - `empty = (word_count==0)`
  - `full = (word_count==DEPTH)`
  - `almost_full = (word_count >= afull_th)`
  - `almost_empty = (word_count <= aempty_th)`
- **Full:** blocks all beats, including beat 0 of a new word. No partial word can exist while full.
- **Empty:** a word committed in the same cycle is not readable until the next cycle; there is no fall-through.
- **overflow:** set on `wr & full`.
- **underflow:** set on `rd & tick & empty`. An `rd` without a tick is not an error.
- **Error clear:** `err_clr` clears both flags, but a set condition in the same cycle wins.
- **flush:** clears `w_ptr`, `r_ptr`, `word_count`, `beat_phase`, `overflow` and `underflow` at the next edge.
  - `flush` overrides `wr`, `rd` and `err_clr` in the same cycle; the partial word is discarded.
  - `data_out` and the tick counter are unaffected.

## Timing
- **Reset values:**
  - `data_out=0`, `rd_valid=0`, `word_count=0`, `beat_phase=0`.
  - Pointers and tick counter = 0.
  - `empty=1`, `full=0`, `almost_empty=1`, `almost_full=0` when `afull_th>0`.
  - `overflow=0`, `underflow=0`.
- **Reset mid-operation:** the asynchronous assert wins immediately, and all state above is forced. The first tick occurs `rd_div` cycles after release.
- **Write to flags:** the edge accepting the final beat updates `word_count` and the flags. They are visible in the next cycle.
- **Read latency:** `rd_en` in cycle N gives `data_out` and `rd_valid=1` in cycle N+1. `rd_valid` falls in N+2 unless another read occurs.
- **Read spacing:** minimum `rd_div+1` cycles between accepted reads.
- **Memory:** inferred as `BEATS` lane arrays with synchronous read. No read-during-write hazard, because a slot being written is never readable.

## Test plan
1. **Packing, default widths:** `DEPTH_LOG2=4`, `rd_div=0`. Write beats `0x…AAAA` (128b) then `0x1111…_2222_3333` (low 64 = `0x2222_3333` pattern); read once.
   - `data_out[127:0]`=beat0, `data_out[191:128]`=beat1[63:0].
   - `rd_valid` pulses 1 cycle after `rd_en`.
   - `word_count` goes 0→1→0.
2. **Full/overflow:** write 32 beats.
   - `full=1` at `word_count=16`.
   - 33rd `wr` is ignored and sets `overflow`; it stays set until `err_clr`.
   - Read 16 words; data arrives in order; `empty=1`.
3. **Pacing:** `rd_div=29`, `rd` held high, 4 words stored.
   - Accepted reads are exactly 30 cycles apart.
   - `rd` on an empty FIFO without a tick leaves `underflow=0`; with a tick it sets `underflow=1`.
4. **Simultaneous events:**
   - `word_count=5`: commit and read in the same cycle keep the count at 5.
   - Count 0 with a commit this cycle: `rd` is refused, and the read succeeds one cycle later.
5. **Thresholds and wrap:** `afull_th=12`, `aempty_th=2`. Stream 40 words through with interleaved reads.
   - `almost_full` asserts at count 12; `almost_empty` deasserts at count 3.
   - Data stays correct across pointer wrap.
6. **Flush/reset mid-word:**
   - Write beat 0, then `flush` together with `wr`: `beat_phase=0`, `word_count=0`, flags cleared, `data_out` unchanged.
   - Assert `rstn=0` mid-stream: all outputs go to reset values asynchronously.
